muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer that shares the multicycle MULT and DIV datapath units with the main control FSM.
//  Accepts one HI/LO-class instruction at a time (MULT, DIV, MTHI, MTLO) and holds the operands stable.
//  Pulses the selected unit's start line and tracks its busy handshake, then commits the result to the HI/LO registers.
//  Stalls the main FSM while a unit is running; flags divide-by-zero and handshake timeouts.
// PARAMETERS
//  WIDTH         32  operand and HI/LO width
//  ACK_TIMEOUT   4   max cycles from unit start pulse to unit busy rising
//  DONE_TIMEOUT  64  max cycles busy may stay high before abort
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low; clears all state
//  start       in   1      request from main FSM; sampled only in IDLE
//  op          in   2      00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//  a, b        in   WIDTH  rs / rt values; sampled with start
//  abort       in   1      exception flush; cancels an operation in flight
//  mult_start  out  1      one-cycle start pulse to the multiplier
//  div_start   out  1      one-cycle start pulse to the divider
//  unit_a      out  WIDTH  registered operand A, held for the whole operation
//  unit_b      out  WIDTH  registered operand B, held for the whole operation
//  unit_clr    out  1      one-cycle sync clear to both units on abort/timeout
//  mult_busy   in   1      multiplier running
//  mult_hi     in   WIDTH  multiplier result, high half
//  mult_lo     in   WIDTH  multiplier result, low half
//  div_busy    in   1      divider running
//  div_hi      in   WIDTH  divider result, high half
//  div_lo      in   WIDTH  divider result, low half
//  hi, lo      out  WIDTH  architectural HI/LO registers
//  stall       out  1      main FSM must hold
//  done        out  1      one-cycle pulse on HI/LO commit
//  div_zero    out  1      one-cycle pulse; DIV with b==0 was rejected
//  err         out  1      one-cycle pulse on handshake timeout
// BEHAVIOUR
//  Reset values: all outputs 0, including hi and lo; state IDLE; timer 0.
//  States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, COMMIT.
//  IDLE + start:
//   - op MTHI/MTLO: write a to hi or lo at the next edge; done pulses that cycle; stay in IDLE; no stall.
//   - DIV with b==0: div_zero pulses at the next edge; HI/LO unchanged; no unit started; stay in IDLE.
//   - Other MULT/DIV: latch op, a, b; go to LAUNCH. stall = start & op[1]==0 (combinational).
//  LAUNCH: the selected *_start is high for exactly this cycle; clear timer; go to WAIT_ACK.
//  WAIT_ACK:
//   - Selected busy==1: go to WAIT_DONE and clear timer.
//   - Timer reaches ACK_TIMEOUT: err and unit_clr pulse; go to IDLE.
//  WAIT_DONE:
//   - Selected busy==0: go to COMMIT.
//   - Timer reaches DONE_TIMEOUT: err and unit_clr pulse; go to IDLE.
//  COMMIT: {hi,lo} <= selected unit {hi,lo}, copied verbatim with no sign fix-up; done pulses; go to IDLE.
//  stall is high in every state except IDLE.
//  Total latency: unit busy length + 3 cycles from start to done.
//  abort in LAUNCH/WAIT_*: unit_clr pulses; go to IDLE; no commit; abort has priority over busy/timeout.
//  abort in COMMIT is ignored; the commit completes.
//  start is ignored outside IDLE.
//  The busy line of the non-selected unit is ignored.
//  unit_a and unit_b change only on an accepted MULT/DIV start.
//  Reset asserted mid-operation: immediate return to IDLE; hi/lo cleared.
// STRUCTURE
//  muldiv_pkg:
//   - op_e enum
//   - state_e enum
//   - OP_MULT, OP_DIV, OP_MTHI, OP_MTLO constants
//  Sub-module wait_timer: saturating counter with clr, en and hit outputs; compared against ACK_TIMEOUT/DONE_TIMEOUT.
// TESTING
//  Bench uses stub unit models whose busy length is set per test.
//  1. DIV a=100, b=7, stub busy 33 cycles:
//     - div_start pulses 1 cycle; stall high 36 cycles.
//     - done pulses once; hi/lo equal the stub outputs.
//  2. DIV a=5, b=0: div_zero pulses 1 cycle; no div_start; hi/lo unchanged; stall never high.
//  3. MTHI a=0xDEADBEEF, then MTLO a=0x1234: hi=0xDEADBEEF, lo=0x1234; done pulses each cycle; no stall.
//  4. MULT whose stub never raises busy: err and unit_clr pulse 5 cycles after mult_start; state back in IDLE; hi/lo unchanged.
//  5. DIV running, abort on busy cycle 10: unit_clr pulses; no done; the next MULT start is accepted normally.
//  6. Async reset low during WAIT_DONE: all outputs 0 immediately; first start after release proceeds normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multicycle sequencer: instruction opcodes and
// sequencer states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_COMMIT
  } state_e;

endpackage

// File: rtl/wait_timer.sv
// Saturating handshake timer; flags when the count has reached the
// acknowledge or completion timeout.
module wait_timer #(
  parameter int ACK_TIMEOUT  = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_ack_hit,
  output logic o_done_hit
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] ACK_CNT  = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] DONE_CNT = CW'(DONE_TIMEOUT);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_ack_hit  = (r_count == ACK_CNT);
  assign o_done_hit = (r_count == DONE_CNT);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer sharing the multicycle MULT/DIV units with the main control FSM:
// launches a unit, tracks its busy handshake and commits the result to HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ACK_TIMEOUT  = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_mult_start,
  output logic             o_div_start,
  output logic [WIDTH-1:0] o_unit_a,
  output logic [WIDTH-1:0] o_unit_b,
  output logic             o_unit_clr,
  input  logic             i_mult_busy,
  input  logic [WIDTH-1:0] i_mult_hi,
  input  logic [WIDTH-1:0] i_mult_lo,
  input  logic             i_div_busy,
  input  logic [WIDTH-1:0] i_div_hi,
  input  logic [WIDTH-1:0] i_div_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_zero,
  output logic             o_err
);

  state_e           r_state, w_next;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_div_zero;

  op_e  w_op;
  logic w_idle_start, w_div_by_zero, w_accept, w_sel_busy;
  logic w_tmr_clr, w_tmr_en, w_ack_hit, w_done_hit;

  assign w_op          = op_e'(i_op);
  assign w_idle_start  = (r_state == S_IDLE) && i_start;
  assign w_div_by_zero = w_idle_start && (w_op == OP_DIV) && (i_b == '0);
  assign w_accept      = w_idle_start && !i_op[1] && !w_div_by_zero;
  // Only the launched unit's handshake matters; the other busy line is ignored.
  assign w_sel_busy    = (r_op == OP_MULT) ? i_mult_busy : i_div_busy;

  wait_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_ack_hit (w_ack_hit),
    .o_done_hit(w_done_hit)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_accept) w_next = S_LAUNCH;
      S_LAUNCH:    w_next = i_abort ? S_IDLE : S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (i_abort)         w_next = S_IDLE;
        else if (w_sel_busy) w_next = S_WAIT_DONE;
        else if (w_ack_hit)  w_next = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (i_abort)          w_next = S_IDLE;
        else if (!w_sel_busy) w_next = S_COMMIT;
        else if (w_done_hit)  w_next = S_IDLE;
      end
      S_COMMIT:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mult_start = 1'b0;
    o_div_start  = 1'b0;
    o_unit_clr   = 1'b0;
    o_stall      = 1'b1;
    o_done       = 1'b0;
    o_err        = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_stall   = w_accept;
        o_done    = w_idle_start && i_op[1];
        w_tmr_clr = 1'b1;
      end
      S_LAUNCH: begin
        o_mult_start = (r_op == OP_MULT);
        o_div_start  = (r_op == OP_DIV);
        o_unit_clr   = i_abort;
        w_tmr_clr    = 1'b1;
      end
      S_WAIT_ACK: begin
        w_tmr_en = 1'b1;
        if (i_abort) begin
          o_unit_clr = 1'b1;
        end else if (w_sel_busy) begin
          w_tmr_clr = 1'b1;
        end else if (w_ack_hit) begin
          o_err      = 1'b1;
          o_unit_clr = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        w_tmr_en = 1'b1;
        if (i_abort) begin
          o_unit_clr = 1'b1;
        end else if (w_sel_busy && w_done_hit) begin
          o_err      = 1'b1;
          o_unit_clr = 1'b1;
        end
      end
      S_COMMIT: o_done = 1'b1;
      default:  o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op       <= OP_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= w_div_by_zero;
      if (w_accept) begin
        r_op <= w_op;
        r_a  <= i_a;
        r_b  <= i_b;
      end
      if (w_idle_start && (w_op == OP_MTHI)) r_hi <= i_a;
      if (w_idle_start && (w_op == OP_MTLO)) r_lo <= i_a;
      // Result halves are copied verbatim; any sign fix-up belongs to the unit.
      if (r_state == S_COMMIT) begin
        r_hi <= (r_op == OP_MULT) ? i_mult_hi : i_div_hi;
        r_lo <= (r_op == OP_MULT) ? i_mult_lo : i_div_lo;
      end
    end
  end

  assign o_unit_a   = r_a;
  assign o_unit_b   = r_b;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: stub MULT/DIV units with a per-test
// busy length, directed scenarios plus randomized operations against a model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int ACK_TO  = 4;
  localparam int DONE_TO = 64;
  localparam int NCYC    = 90;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         mult_start, div_start, unit_clr, stall, done, div_zero, err;
  logic         mult_busy, div_busy;
  logic [W-1:0] unit_a, unit_b, hi, lo;
  logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;

  int   total = 0;
  int   bad   = 0;
  int   busy_len = 0;
  int   m_cnt, d_cnt;
  logic mult_noise = 1'b0, div_noise = 1'b0;

  // Reference architectural state.
  logic [W-1:0] m_hi = '0, m_lo = '0, m_ua = '0, m_ub = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(W), .ACK_TIMEOUT(ACK_TO), .DONE_TIMEOUT(DONE_TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_abort(abort), .o_mult_start(mult_start), .o_div_start(div_start),
    .o_unit_a(unit_a), .o_unit_b(unit_b), .o_unit_clr(unit_clr),
    .i_mult_busy(mult_busy), .i_mult_hi(mult_hi), .i_mult_lo(mult_lo),
    .i_div_busy(div_busy), .i_div_hi(div_hi), .i_div_lo(div_lo),
    .o_hi(hi), .o_lo(lo), .o_stall(stall), .o_done(done),
    .o_div_zero(div_zero), .o_err(err)
  );

  // Stub units: busy for busy_len cycles after their start pulse (0 = never).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          m_cnt <= 0;
    else if (unit_clr)   m_cnt <= 0;
    else if (mult_start) m_cnt <= busy_len;
    else if (m_cnt > 0)  m_cnt <= m_cnt - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          d_cnt <= 0;
    else if (unit_clr)   d_cnt <= 0;
    else if (div_start)  d_cnt <= busy_len;
    else if (d_cnt > 0)  d_cnt <= d_cnt - 1;
  end
  assign mult_busy = (m_cnt > 0) || mult_noise;
  assign div_busy  = (d_cnt > 0) || div_noise;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction issued at cycle 0, observed for NCYC cycles. Expected event
  // cycles come from the sequencing rules: launch at 1, busy seen from 2, done
  // after busy length + 3, ack timeout 5 cycles after the start pulse.
  task automatic run_op(input string lbl, input logic [1:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input int len, input int abort_k);
    int   f_done = -1, n_done = 0, f_err = -1, n_err = 0, f_clr = -1, n_clr = 0;
    int   f_ms = -1, n_ms = 0, f_ds = -1, n_ds = 0, f_dz = -1, n_dz = 0, n_stall = 0;
    int   e_done = -1, e_err = -1, e_clr = -1, e_dz = -1, e_st = -1, e_end = 0;
    logic stall0 = 1'b0;
    bit   is_mt, is_dz, launched;

    is_mt    = o[1];
    is_dz    = (o == OP_DIV) && (vb == '0);
    launched = !is_mt && !is_dz;
    if (is_mt) e_done = 0;
    else if (is_dz) e_dz = 1;
    else begin
      e_st = 1;
      if (len == 0) begin
        e_err = ACK_TO + 2; e_clr = e_err;
      end else if (abort_k > 0 && abort_k <= len + 1) begin
        e_clr = abort_k + 1;
      end else if (len >= DONE_TO + 2) begin
        e_err = DONE_TO + 3; e_clr = e_err;
      end else begin
        e_done = len + 3;
      end
      e_end = (e_done >= 0) ? e_done : e_clr;
    end

    busy_len = len;
    mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
    if (launched) begin
      if (o == OP_MULT) div_noise = 1'($urandom_range(0, 1));
      else              mult_noise = 1'($urandom_range(0, 1));
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // A stray MTHI at cycle 2 must be ignored while an operation is in flight.
      start = (cyc == 0) || (launched && cyc == 2);
      op    = (cyc == 0) ? o : 2'(OP_MTHI);
      a     = (cyc == 0) ? va : ~va;
      b     = (cyc == 0) ? vb : ~vb;
      abort = launched && (abort_k > 0) && (cyc == abort_k + 1);
      #2;
      if (done)       begin n_done++; if (f_done < 0) f_done = cyc; end
      if (err)        begin n_err++;  if (f_err  < 0) f_err  = cyc; end
      if (unit_clr)   begin n_clr++;  if (f_clr  < 0) f_clr  = cyc; end
      if (mult_start) begin n_ms++;   if (f_ms   < 0) f_ms   = cyc; end
      if (div_start)  begin n_ds++;   if (f_ds   < 0) f_ds   = cyc; end
      if (div_zero)   begin n_dz++;   if (f_dz   < 0) f_dz   = cyc; end
      if (cyc == 0) stall0 = stall;
      else if (stall) n_stall++;
      next_cycle();
    end
    start = 1'b0; abort = 1'b0; mult_noise = 1'b0; div_noise = 1'b0;

    if (is_mt && o == OP_MTHI) m_hi = va;
    if (is_mt && o == OP_MTLO) m_lo = va;
    if (launched) begin
      m_ua = va; m_ub = vb;
      if (e_done >= 0) begin
        m_hi = (o == OP_MULT) ? mult_hi : div_hi;
        m_lo = (o == OP_MULT) ? mult_lo : div_lo;
      end
    end

    check({lbl, " done_at"},   64'(f_done), 64'(e_done));
    check({lbl, " done_cnt"},  64'(n_done), 64'(e_done >= 0));
    check({lbl, " err_at"},    64'(f_err),  64'(e_err));
    check({lbl, " err_cnt"},   64'(n_err),  64'(e_err >= 0));
    check({lbl, " clr_at"},    64'(f_clr),  64'(e_clr));
    check({lbl, " clr_cnt"},   64'(n_clr),  64'(e_clr >= 0));
    check({lbl, " dz_at"},     64'(f_dz),   64'(e_dz));
    check({lbl, " dz_cnt"},    64'(n_dz),   64'(e_dz >= 0));
    check({lbl, " mstart_at"}, 64'(f_ms),   64'((o == OP_MULT) ? e_st : -1));
    check({lbl, " mstart_n"},  64'(n_ms),   64'((o == OP_MULT) && launched));
    check({lbl, " dstart_at"}, 64'(f_ds),   64'((o == OP_DIV) ? e_st : -1));
    check({lbl, " dstart_n"},  64'(n_ds),   64'((o == OP_DIV) && launched));
    check({lbl, " stall0"},    64'(stall0), 64'(launched));
    check({lbl, " stall_n"},   64'(n_stall), 64'(e_end));
    check({lbl, " hi"},        64'(hi),     64'(m_hi));
    check({lbl, " lo"},        64'(lo),     64'(m_lo));
    check({lbl, " unit_a"},    64'(unit_a), 64'(m_ua));
    check({lbl, " unit_b"},    64'(unit_b), 64'(m_ub));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    #12;
    check("reset ctrl", 64'({mult_start, div_start, unit_clr, stall, done, div_zero, err}), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset unit", {unit_a, unit_b}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    run_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 33, 0);
    run_op("div_by_0",   OP_DIV,  32'd5,   32'd0, 10, 0);

    // Back-to-back MTHI / MTLO.
    start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
    #2;
    check("mthi done",  64'(done),  64'd1);
    check("mthi stall", 64'(stall), 64'd0);
    next_cycle();
    op = OP_MTLO; a = 32'h1234;
    #2;
    check("mtlo done",  64'(done),  64'd1);
    check("mtlo stall", 64'(stall), 64'd0);
    next_cycle();
    start = 1'b0;
    #2;
    m_hi = 32'hDEADBEEF; m_lo = 32'h1234;
    check("mt hi",      64'(hi),   64'(m_hi));
    check("mt lo",      64'(lo),   64'(m_lo));
    check("mt idle",    64'(done), 64'd0);
    next_cycle();

    run_op("mult_noack",  OP_MULT, $urandom, $urandom, 0, 0);
    run_op("div_abort",   OP_DIV,  $urandom, 32'd9, 20, 10);
    run_op("mult_after",  OP_MULT, $urandom, $urandom, 5, 0);
    run_op("div_abort_c", OP_DIV,  $urandom, 32'd3, 8, 10);
    run_op("div_abort_w", OP_DIV,  $urandom, 32'd3, 8, 9);
    run_op("mult_doneto", OP_MULT, $urandom, $urandom, 80, 0);
    run_op("mult_len1",   OP_MULT, $urandom, $urandom, 1, 0);

    for (int i = 0; i < 14; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rb;
      int           rl, rk;
      ro = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      rl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      rk = (rl > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, rl + 2)) : 0;
      run_op($sformatf("rand%0d", i), ro, W'($urandom), rb, rl, rk);
    end

    // Asynchronous reset in the middle of a DIV.
    busy_len = 33;
    start = 1'b1; op = OP_DIV; a = 32'd77; b = 32'd3;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 9; i++) next_cycle();
    #1;
    check("pre-reset stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async ctrl", 64'({mult_start, div_start, unit_clr, stall, done, div_zero, err}), 64'd0);
    check("async hilo", {hi, lo}, 64'd0);
    check("async unit", {unit_a, unit_b}, 64'd0);
    m_hi = '0; m_lo = '0; m_ua = '0; m_ub = '0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    run_op("post_reset", OP_MULT, $urandom, $urandom, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
